// File: rtl/qdr_dly_tap_ctrl.sv
// qdr_dly_tap_ctrl: turns per-line delay-enable pulses into paced IODELAY CE/INC strobes
// and keeps a saturating shadow tap counter for every line.
module qdr_dly_tap_ctrl #(
   parameter int N_DI          = 36,
   parameter int N_DO          = 37,
   parameter int TAP_W         = 5,
   parameter int INIT_TAP      = 0,
   parameter int SETTLE_CYCLES = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [N_DI-1:0]               dly_en_i,
   input  logic [N_DO-1:0]               dly_en_o,
   input  logic                          dly_inc_dec,
   output logic [N_DI+N_DO-1:0]          idelay_ce,
   output logic                          idelay_inc,
   output logic [TAP_W*(N_DI+N_DO)-1:0]  dly_cntrs,
   output logic                          dly_busy,
   output logic                          dly_sat
);
   localparam int N  = N_DI + N_DO;
   localparam int SW = $clog2(SETTLE_CYCLES + 1);
   localparam logic [TAP_W-1:0] MAX = '1;
   typedef enum logic [1:0] {IDLE, STROBE, SETTLE} state_t;
   state_t            state;
   logic [N-1:0]      pend, lim, req;
   logic [SW-1:0]     settle;
   logic [TAP_W-1:0]  cnt [N];
   logic              take;
   assign req      = {dly_en_o, dly_en_i};
   assign take     = state == IDLE && |pend;
   assign dly_busy = state != IDLE || |pend;
   for (genvar g = 0; g < N; g++) begin : g_line
      assign lim[g] = dly_inc_dec ? cnt[g] == MAX : cnt[g] == '0;
      assign dly_cntrs[TAP_W*g +: TAP_W] = cnt[g];
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         pend       <= '0;
         idelay_ce  <= '0;
         idelay_inc <= 1'b0;
         dly_sat    <= 1'b0;
         settle     <= '0;
         for (int i = 0; i < N; i++) cnt[i] <= TAP_W'(INIT_TAP);
      end else begin
         // taken bits drop out, but pulses arriving this same cycle stay queued
         pend <= take ? req : pend | req;
         case (state)
            IDLE: if (take) begin
               idelay_ce  <= pend & ~lim;
               idelay_inc <= dly_inc_dec;
               dly_sat    <= dly_sat | |(pend & lim);
               state      <= STROBE;
            end
            STROBE: begin
               for (int i = 0; i < N; i++)
                  if (idelay_ce[i]) cnt[i] <= idelay_inc ? cnt[i] + 1'b1 : cnt[i] - 1'b1;
               idelay_ce <= '0;
               settle    <= SW'(SETTLE_CYCLES - 1);
               state     <= SETTLE;
            end
            SETTLE: if (settle == '0) state <= IDLE; else settle <= settle - 1'b1;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_qdr_dly_tap_ctrl.sv
// tb_qdr_dly_tap_ctrl: directed scenarios plus random pulses, checked every cycle against
// a cooldown-based behavioural model of the tap controller.
module tb_qdr_dly_tap_ctrl;
   localparam int N_DI = 36, N_DO = 37, N = 73, TW = 5, SET = 4;
   logic clk = 0, rst = 1;
   logic [N_DI-1:0] dly_en_i = '0;
   logic [N_DO-1:0] dly_en_o = '0;
   logic dly_inc_dec = 0;
   logic [N-1:0] idelay_ce;
   logic idelay_inc, dly_busy, dly_sat;
   logic [TW*N-1:0] dly_cntrs;
   int errs = 0, checks = 0;
   always #5 clk = ~clk;

   qdr_dly_tap_ctrl dut (
      .clk(clk), .rst(rst), .dly_en_i(dly_en_i), .dly_en_o(dly_en_o),
      .dly_inc_dec(dly_inc_dec), .idelay_ce(idelay_ce), .idelay_inc(idelay_inc),
      .dly_cntrs(dly_cntrs), .dly_busy(dly_busy), .dly_sat(dly_sat)
   );

   // model: a strobe fires one edge after a request is seen with no cooldown running,
   // then the next one is blocked for SET+1 further cycles
   logic [TW-1:0] mcnt [N];
   logic [N-1:0] mpend, mce;
   logic minc, msat, started = 0;
   int timer;
   always @(posedge clk) begin
      logic [N-1:0] r, lim;
      r = {dly_en_o, dly_en_i};
      if (rst) begin
         for (int n = 0; n < N; n++) mcnt[n] = '0;
         mpend = '0; mce = '0; minc = 0; msat = 0; timer = 0; started = 1;
      end else begin
         for (int n = 0; n < N; n++) if (mce[n]) mcnt[n] = minc ? mcnt[n] + 1'b1 : mcnt[n] - 1'b1;
         if (timer == 0 && mpend != '0) begin
            for (int n = 0; n < N; n++) lim[n] = dly_inc_dec ? mcnt[n] == 5'd31 : mcnt[n] == 5'd0;
            mce = mpend & ~lim; minc = dly_inc_dec; msat = msat | |(mpend & lim);
            mpend = r; timer = SET + 1;
         end else begin
            mce = '0; mpend = mpend | r;
            if (timer > 0) timer--;
         end
      end
   end

   task automatic chk(input string nm, input logic [511:0] got, input logic [511:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
      end
   endtask

   always @(negedge clk) if (started) begin
      logic [TW*N-1:0] ec;
      for (int n = 0; n < N; n++) ec[TW*n +: TW] = mcnt[n];
      chk("m_ce", idelay_ce, mce);
      chk("m_inc", idelay_inc, minc);
      chk("m_cntrs", dly_cntrs, ec);
      chk("m_busy", dly_busy, timer != 0 || mpend != '0);
      chk("m_sat", dly_sat, msat);
   end

   task automatic step(); @(negedge clk); #1; endtask
   task automatic steps(input int k); for (int i = 0; i < k; i++) step(); endtask
   function automatic logic [TW-1:0] cn(input int n); return dly_cntrs[TW*n +: TW]; endfunction
   task automatic set_line(input int n);
      if (n < N_DI) dly_en_i[n] = 1; else dly_en_o[n-N_DI] = 1;
   endtask
   task automatic clr(); dly_en_i = '0; dly_en_o = '0; endtask
   task automatic do_reset(); rst = 1; clr(); steps(2); rst = 0; endtask
   task automatic pulse(input int n, input logic inc);
      set_line(n); dly_inc_dec = inc; step(); clr();
   endtask
   task automatic wait_idle();
      int k = 0;
      while (dly_busy && k < 50) begin step(); k++; end
      if (dly_busy) chk("idle_timeout", 1, 0);
   endtask

   initial begin
      logic [N-1:0] e;
      logic [TW*N-1:0] ev;
      int first, second, nstb;
      step(); do_reset();
      chk("rst_cntrs", dly_cntrs, 0);
      chk("rst_busy", dly_busy, 0);
      // 1: single increment, exact latency
      step(); pulse(3, 1);
      chk("t1_ce_t1", idelay_ce, 0);
      step(); e = '0; e[3] = 1;
      chk("t1_ce_t2", idelay_ce, e);
      chk("t1_inc", idelay_inc, 1);
      chk("t1_cnt_t2", cn(3), 0);
      step(); ev = '0; ev[15] = 1;
      chk("t1_ce_t3", idelay_ce, 0);
      chk("t1_cntrs_t3", dly_cntrs, ev);
      wait_idle();
      // 2: decrement at zero saturates
      pulse(36, 0); step();
      chk("t2_ce", idelay_ce, 0);
      step();
      chk("t2_cnt", cn(36), 0);
      chk("t2_sat", dly_sat, 1);
      wait_idle();
      // 3: climb line 5 to max, saturate, step back
      do_reset();
      for (int i = 0; i < 31; i++) begin pulse(5, 1); steps(9); end
      chk("t3_cnt31", cn(5), 31);
      chk("t3_nosat", dly_sat, 0);
      pulse(5, 1); step();
      chk("t3_no_ce", idelay_ce, 0);
      steps(8);
      chk("t3_cnt_hold", cn(5), 31);
      chk("t3_sat", dly_sat, 1);
      pulse(5, 0); steps(9);
      chk("t3_cnt30", cn(5), 30);
      // 4: two lines share a strobe
      do_reset();
      set_line(1); set_line(40); dly_inc_dec = 1; step(); clr(); step();
      e = '0; e[1] = 1; e[40] = 1;
      chk("t4_ce", idelay_ce, e);
      step();
      chk("t4_cnt1", cn(1), 1);
      chk("t4_cnt40", cn(40), 1);
      wait_idle();
      // 5: repeat requests during settle are queued, not lost, and spaced
      do_reset();
      first = -1; second = -1; nstb = 0;
      pulse(2, 1);
      for (int c = 0; c < 30; c++) begin
         if (c == 3 || c == 10) set_line(2);
         step(); clr();
         if (idelay_ce[2]) begin
            nstb++;
            if (first < 0) first = c; else if (second < 0) second = c;
         end
      end
      chk("t5_strobes", nstb, 3);
      chk("t5_spacing", (second - first) >= SET + 2, 1);
      chk("t5_cnt", cn(2), 3);
      // 6: reset during strobe with work pending
      do_reset();
      pulse(7, 1); step();
      chk("t6_in_strobe", idelay_ce[7], 1);
      set_line(8); rst = 1; step(); clr();
      chk("t6_ce", idelay_ce, 0);
      chk("t6_cntrs", dly_cntrs, 0);
      chk("t6_busy", dly_busy, 0);
      rst = 0;
      // random traffic, checked by the model every cycle
      for (int c = 0; c < 1500; c++) begin
         clr();
         if ($urandom_range(0, 2) == 0) set_line($urandom_range(0, N-1));
         if ($urandom_range(0, 5) == 0) set_line($urandom_range(0, N-1));
         dly_inc_dec = $urandom_range(0, 3) != 0;
         rst = $urandom_range(0, 299) == 0;
         step();
      end
      rst = 0; clr(); steps(3);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
